// File: rtl/disp_byte_pacer.sv
// Purpose: buffers bytes from a byte receiver and scrolls them into an 8-nibble display window, one byte per tick.
// Latency: a byte pushed into an empty FIFO reaches d1/d0 the cycle after the next tick (at most CLKFREQ/SHIFT_HZ+1 cycles).
// Backpressure: din_ready drops when the FIFO is full or during clear/reset; a byte offered while full is dropped and sets overflow.
module disp_byte_pacer #(
  parameter int CLKFREQ  = 100_000_000,
  parameter int SHIFT_HZ = 4,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               din,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic                     clear,
  input  logic                     hold,
  output logic [3:0]               d7,
  output logic [3:0]               d6,
  output logic [3:0]               d5,
  output logic [3:0]               d4,
  output logic [3:0]               d3,
  output logic [3:0]               d2,
  output logic [3:0]               d1,
  output logic [3:0]               d0,
  output logic                     dp7,
  output logic                     dp6,
  output logic                     dp5,
  output logic                     dp4,
  output logic                     dp3,
  output logic                     dp2,
  output logic                     dp1,
  output logic                     dp0,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PERIOD = CLKFREQ / SHIFT_HZ;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [31:0]   win;   // d7 in the top nibble, d0 in the bottom nibble
  logic [3:0]    dpe;   // even decimal points: bit0=dp0, bit1=dp2, bit2=dp4, bit3=dp6

  assign tick  = (tick_cnt == CNT_MAX);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

  // Ready depends only on registered full plus clear/reset, never on din_valid.
  assign din_ready  = ~full & ~clear & ~reset;
  assign push       = din_valid & din_ready;
  assign pop        = tick & ~empty & ~hold & ~clear;
  assign fifo_count = wptr - rptr;

  // Free-running tick counter; clear and hold deliberately leave its phase alone.
  always_ff @(posedge clk) begin
    if (reset)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  // FIFO storage; push is already gated by clear and reset through din_ready.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[AW-1:0]] <= din;
  end

  // FIFO pointers; simultaneous push and pop both advance, leaving occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Scrolling window and byte-boundary markers advance by one byte per pop.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      win <= '0;
      dpe <= '0;
    end else if (pop) begin
      win <= {win[23:0], mem[rptr[AW-1:0]]};
      dpe <= {dpe[2:0], 1'b1};
    end
  end

  // Sticky overflow flag: set when a byte is offered while the FIFO is full.
  always_ff @(posedge clk) begin
    if (reset || clear)
      overflow <= 1'b0;
    else if (din_valid && full)
      overflow <= 1'b1;
  end

  assign d7  = win[31:28];
  assign d6  = win[27:24];
  assign d5  = win[23:20];
  assign d4  = win[19:16];
  assign d3  = win[15:12];
  assign d2  = win[11:8];
  assign d1  = win[7:4];
  assign d0  = win[3:0];
  assign dp6 = dpe[3];
  assign dp4 = dpe[2];
  assign dp2 = dpe[1];
  assign dp0 = dpe[0];
  assign dp7 = 1'b0;
  assign dp5 = 1'b0;
  assign dp3 = 1'b0;
  assign dp1 = 1'b0;

endmodule

// File: doc/disp_byte_pacer.md
Name: disp_byte_pacer

Overview:
Upstream feeder for the 8-digit seven-segment controller. Accepts received bytes over a valid/ready handshake and buffers them in a small FIFO. Releases one byte per display tick into an 8-nibble scrolling window, so a human can read bursty receiver traffic. Outputs d7..d0 and dp7..dp0 connect directly to the display controller's digit and decimal-point inputs.

Parameters:
CLKFREQ, 100_000_000, input clock frequency in Hz
SHIFT_HZ, 4, scroll rate in bytes per second; tick period = CLKFREQ/SHIFT_HZ cycles (integer, >=2)
DEPTH, 8, FIFO depth in bytes; power of 2, >=2

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
din  input  8  received byte
din_valid  input  1  din holds a byte to transfer
din_ready  output  1  block can accept a byte this cycle
clear  input  1  synchronous flush of FIFO, window and flags
hold  input  1  freeze scrolling; FIFO keeps filling
d7..d0  output  4 each  hex nibbles for display digits 7..0
dp7..dp0  output  1 each  decimal-point enables, 1 = lit
overflow  output  1  sticky: a byte was offered while FIFO full
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset; all state changes on the rising edge of clk.
- Reset (reset=1 at edge):
  - FIFO empty, fifo_count=0.
  - d7..d0=0, dp7..dp0=0, overflow=0.
  - Tick counter = 0.
  - din_ready=0 while reset is high; din_ready=1 in the first cycle after reset.
- Handshake:
  - din_ready = ~full & ~clear & ~reset (combinational from registered full).
  - Push occurs when din_valid & din_ready.
  - din may change freely when din_ready=0.
  - No combinational path from din_valid to din_ready.
- Tick counter:
  - Free-runs 0..CLKFREQ/SHIFT_HZ-1, then wraps to 0.
  - tick is asserted for one cycle when the counter equals max.
  - The counter runs regardless of hold and FIFO state.
- Pop: occurs on a tick cycle when FIFO is non-empty, hold=0 and clear=0.
- Window shift on pop (registered, visible the next cycle):
  - d7<=d5, d6<=d4, d5<=d3, d4<=d2, d3<=d1, d2<=d0, d1<=byte[7:4], d0<=byte[3:0].
- Decimal points mark byte boundaries of valid slots:
  - On pop, dp6<=dp4, dp4<=dp2, dp2<=dp0, dp0<=1.
  - Odd dps are always 0.
  - After N pops since clear/reset, exactly min(N,4) of dp0/2/4/6 are lit, filled from dp0 upward.
- Simultaneous push and pop: both take effect; fifo_count is unchanged; FIFO order is preserved.
- Full: push is refused. If din_valid=1 while full, overflow<=1 and the byte is dropped; FIFO contents are untouched.
- Empty on tick: nothing happens; window holds.
- Wrap-around: FIFO read and write pointers are $clog2(DEPTH)+1 bits. full = pointer MSBs differ and the rest are equal; empty = pointers equal.
- clear=1:
  - Empties the FIFO, zeroes d*/dp*/overflow, and forces din_ready=0.
  - Any push or pop in that cycle is discarded.
  - The tick counter is NOT reset.
- Priority: reset > clear > pop/push.
- Latency:
  - A byte pushed at cycle t into an empty FIFO appears on d1/d0 the cycle after the first tick at cycle >= t+1.
  - Worst case: CLKFREQ/SHIFT_HZ+1 cycles.
- hold mid-stream: pops are suppressed while hold=1. The first tick after hold falls pops exactly one byte; no catch-up burst occurs.

Test Plan:
(Use CLKFREQ=100, SHIFT_HZ=10, DEPTH=4; tick every 10 cycles.)
- Reset then push 0xA5 once -> din_ready=1; on cycle after next tick d1=A, d0=5, dp0=1, others 0, fifo_count back to 0.
- Push 0x12,0x34,0x56,0x78,0x9A on consecutive cycles with no tick -> first 4 accepted, din_ready=0 after 4th, 0x9A dropped, overflow=1. After 4 ticks: d7..d0=1,2,3,4,5,6,7,8 and dp6/4/2/0=1.
- Push on the exact tick cycle with FIFO holding 1 byte -> pop and push both occur, fifo_count stays 1, order preserved.
- hold=1 for 3 ticks with 3 bytes queued -> window unchanged. Release hold -> one byte per subsequent tick, not 3 at once.
- Assert clear with FIFO holding 2 bytes and din_valid=1 -> next cycle fifo_count=0, all d/dp=0, overflow=0, presented byte not stored. Tick phase is unchanged.
- Assert reset mid-stream with FIFO holding 3 bytes -> all outputs 0, din_ready=0 during reset, 1 the cycle after. No stale byte appears on later ticks.
